// File: rtl/uart_stream_bridge.sv
// UART rx -> circular FIFO -> four-phase parallel port, with running CRC-8 (poly 0x07) over stored words.
// Word lands in the FIFO 1 cycle after the stop sample; output stalls on out_ack; optional parity bit under UART_PARITY_EN.
module uart_stream_bridge #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1160,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     out_ack,
  input  logic                     crc_clr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [7:0]               crc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     frame_err,
  output logic [7:0]               overflow_cnt
`ifdef UART_PARITY_EN
  , output logic                   parity_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [DW-1:0] HALF_BIT = DW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DW-1:0] FULL_BIT = DW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef UART_PARITY_EN
    R_PARITY,
`endif
    R_STOP
  } rxState_t;

  typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL} outState_t;

  logic              rxMeta, rxS, ackMeta, ackS;
  rxState_t          rxState;
  outState_t         outState;
  logic [DW-1:0]     divCnt;
  logic [BW-1:0]     bitCnt;
  logic [DATA_W-1:0] shiftReg, pushDat, crcWord;
  logic              pushReq, parityBad, crcPend;
  logic              doPush, doPop, dropWord;
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [CW-1:0]     nextCount;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [7:0] crcStep(input logic [7:0] c, input logic [DATA_W-1:0] d);
    logic [7:0] r;
    r = c;
    for (int i = DATA_W - 1; i >= 0; i--)
      r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta  <= 1'b1;
      rxS     <= 1'b1;
      ackMeta <= 1'b0;
      ackS    <= 1'b0;
    end else begin
      rxMeta  <= rx;
      rxS     <= rxMeta;
      ackMeta <= out_ack;
      ackS    <= ackMeta;
    end
  end

`ifndef UART_PARITY_EN
  assign parityBad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxState   <= R_IDLE;
      divCnt    <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      pushReq   <= 1'b0;
      pushDat   <= '0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parityBad  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      pushReq   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (rxState)
        R_IDLE: begin
          divCnt <= '0;
          if (!rxS) rxState <= R_START;
        end
        // A start bit that is no longer low at mid-bit is treated as line noise.
        R_START: begin
          if (divCnt == HALF_BIT) begin
            divCnt  <= '0;
            bitCnt  <= '0;
            rxState <= rxS ? R_IDLE : R_DATA;
          end else divCnt <= divCnt + DW'(1);
        end
        R_DATA: begin
          if (divCnt == FULL_BIT) begin
            divCnt   <= '0;
            shiftReg <= {rxS, shiftReg[DATA_W-1:1]};
            if (bitCnt == LAST_BIT)
`ifdef UART_PARITY_EN
              rxState <= R_PARITY;
`else
              rxState <= R_STOP;
`endif
            else bitCnt <= bitCnt + BW'(1);
          end else divCnt <= divCnt + DW'(1);
        end
`ifdef UART_PARITY_EN
        R_PARITY: begin
          if (divCnt == FULL_BIT) begin
            divCnt    <= '0;
            parityBad <= rxS ^ (^shiftReg);
            rxState   <= R_STOP;
          end else divCnt <= divCnt + DW'(1);
        end
`endif
        R_STOP: begin
          if (divCnt == FULL_BIT) begin
            divCnt  <= '0;
            rxState <= R_IDLE;
            if (rxS && !parityBad) begin
              pushReq <= 1'b1;
              pushDat <= shiftReg;
            end
            if (!rxS) frame_err <= 1'b1;
`ifdef UART_PARITY_EN
            parity_err <= parityBad;
`endif
          end else divCnt <= divCnt + DW'(1);
        end
        default: rxState <= R_IDLE;
      endcase
    end
  end

  // Full/empty are judged on the registered occupancy, i.e. before any same-cycle pop.
  always_comb begin
    doPush    = pushReq && !fifo_full;
    dropWord  = pushReq && fifo_full;
    doPop     = (outState == O_IDLE) && !fifo_empty && !ackS;
    nextCount = fifo_count + CW'(doPush) - CW'(doPop);
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushDat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr        <= '0;
      fifo_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      overflow_cnt <= '0;
      crc          <= '0;
      crcPend      <= 1'b0;
      crcWord      <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (dropWord && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
      fifo_count <= nextCount;
      fifo_empty <= (nextCount == '0);
      fifo_full  <= (nextCount == CW'(DEPTH));
      crcPend    <= doPush;
      if (doPush) crcWord <= pushDat;
      if (crcPend) crc <= crcStep(crc_clr ? 8'h00 : crc, crcWord);
      else if (crc_clr) crc <= 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outState  <= O_IDLE;
      rdPtr     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (outState)
        O_IDLE: if (doPop) begin
          out_data  <= mem[rdPtr];
          out_valid <= 1'b1;
          rdPtr     <= rdPtr + AW'(1);
          outState  <= O_REQ;
        end
        O_REQ: if (ackS) begin
          out_valid <= 1'b0;
          outState  <= O_REL;
        end
        O_REL: if (!ackS) outState <= O_IDLE;
        default: outState <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Randomized bench for uart_stream_bridge: queue-based scoreboard with a monitor on the four-phase port.
module tb_uart_stream_bridge;
  localparam int DEPTH = 4;
  localparam int CPB   = 16;

  logic       clk = 1'b0;
  logic       rstN, rx, outAck, crcClr;
  logic [7:0] outData, crc, overflowCnt;
  logic       outValid, fifoEmpty, fifoFull, frameErr;
  logic [2:0] fifoCount;

  uart_stream_bridge #(.DATA_W(8), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rstN), .rx(rx), .out_ack(outAck), .crc_clr(crcClr),
    .out_data(outData), .out_valid(outValid), .crc(crc), .fifo_count(fifoCount),
    .fifo_empty(fifoEmpty), .fifo_full(fifoFull), .frame_err(frameErr),
    .overflow_cnt(overflowCnt)
  );

  always #5 clk = ~clk;

  int         nChecks = 0, nFails = 0;
  int         held = 0, expOvf = 0, expFe = 0, feCount = 0;
  logic [7:0] expCrc = 8'h00;
  logic [7:0] expQ[$];
  bit         ackEn = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC as the remainder of (crc ^ word) * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = {c ^ d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (v[i]) v[i-:9] = v[i-:9] ^ 9'h107;
    return v[7:0];
  endfunction

  task automatic driveFrame(input logic [7:0] b, input bit stopOk);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopOk;
    repeat (CPB - 4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + 4) @(negedge clk);
  endtask

  // Words in flight (FIFO plus output register) cap at DEPTH+1.
  task automatic sendWord(input logic [7:0] b, input bit stopOk);
    if (!stopOk) expFe++;
    else if (held < DEPTH + 1) begin
      expQ.push_back(b);
      held++;
      expCrc = crc8(expCrc, b);
    end else if (expOvf < 255) expOvf++;
    driveFrame(b, stopOk);
  endtask

  task automatic drain();
    bit done;
    done  = 1'b0;
    ackEn = 1'b1;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      done = (expQ.size() == 0) && (held == 0) && !outValid && !outAck;
    end
    check("drain", 32'(done), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic checkStatus(input string tag, input int expCount);
    check({tag, " crc"}, 32'(crc), 32'(expCrc));
    check({tag, " fifo_count"}, 32'(fifoCount), expCount);
    check({tag, " fifo_empty"}, 32'(fifoEmpty), 32'(expCount == 0));
    check({tag, " fifo_full"}, 32'(fifoFull), 32'(expCount == DEPTH));
    check({tag, " overflow_cnt"}, 32'(overflowCnt), expOvf);
  endtask

  initial begin
    outAck = 1'b0;
    forever begin
      int dly;
      @(negedge clk);
      if (!rstN) outAck = 1'b0;
      else if (outAck && !outValid) outAck = 1'b0;
      else if (ackEn && outValid && !outAck) begin
        if (dly <= 0) begin
          outAck = 1'b1;
          dly = $urandom_range(0, 3);
        end else dly--;
      end
    end
  end

  initial begin
    logic       prevValid;
    logic [7:0] lastData, e;
    prevValid = 1'b0;
    lastData  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstN) prevValid = 1'b0;
      else begin
        if (frameErr) feCount++;
        if (outValid && !prevValid) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL word: got unexpected 0x%0h, expected none", outData);
          end else begin
            e = expQ.pop_front();
            check("word", 32'(outData), 32'(e));
          end
          lastData = outData;
        end else if (outValid) check("hold", 32'(outData), 32'(lastData));
        else if (prevValid) begin
          check("retain", 32'(outData), 32'(lastData));
          held--;
        end
        prevValid = outValid;
      end
    end
  end

  initial begin
    rstN = 1'b0; rx = 1'b1; crcClr = 1'b0;
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(outValid), 0);
    check("reset frame_err", 32'(frameErr), 0);
    checkStatus("reset", 0);

    // Single word with prompt acknowledge.
    ackEn = 1'b1;
    sendWord(8'hA5, 1'b1);
    drain();
    checkStatus("A5", 0);
    check("A5 crc const", 32'(crc), 32'h72);

    @(negedge clk) crcClr = 1'b1;
    @(negedge clk) crcClr = 1'b0;
    expCrc = 8'h00;
    check("crc_clr", 32'(crc), 0);

    // Acknowledge withheld: one word parks in the output register.
    ackEn = 1'b0;
    sendWord(8'h31, 1'b1);
    sendWord(8'h32, 1'b1);
    sendWord(8'h33, 1'b1);
    checkStatus("held3", 2);
    check("held3 out_valid", 32'(outValid), 1);
    drain();
    checkStatus("seq3", 0);
    check("seq3 crc const", 32'(crc), 32'hC0);

    // Overflow: sixth word finds the FIFO full.
    ackEn = 1'b0;
    for (int i = 0; i < 6; i++) sendWord(8'($urandom_range(0, 255)), 1'b1);
    checkStatus("ovf", held - 1);
    check("ovf count", expOvf, 1);
    drain();
    checkStatus("ovf drained", 0);

    // Bad stop bit, then a short glitch on idle rx.
    feCount = 0; expFe = 0;
    sendWord(8'h5A, 1'b0);
    check("frame_err pulses", feCount, expFe);
    checkStatus("frame", 0);
    feCount = 0;
    @(negedge clk) rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch frame_err", feCount, 0);
    check("glitch out_valid", 32'(outValid), 0);
    checkStatus("glitch", 0);

    // crc_clr coinciding with the update of a stored 0x01.
    ackEn = 1'b0;
    fork
      sendWord(8'h01, 1'b1);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (fifoCount == 3'd1) begin
            crcClr = 1'b1;
            @(negedge clk) crcClr = 1'b0;
            seen = 1'b1;
          end
        end
        check("crc_clr window", 32'(seen), 1);
      end
    join
    expCrc = crc8(8'h00, 8'h01);
    check("crc_clr+update", 32'(crc), 32'h07);
    check("crc_clr model", 32'(crc), 32'(expCrc));
    check("pre-reset out_valid", 32'(outValid), 1);

    // Reset in the middle of a data phase while a word is presented.
    fork
      driveFrame(8'hC3, 1'b1);
      begin
        repeat (60) @(negedge clk);
        #2 rstN = 1'b0;
        #1 check("async out_valid", 32'(outValid), 0);
      end
    join
    expQ.delete(); held = 0; expCrc = 8'h00; expOvf = 0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    check("rst out_data", 32'(outData), 0);
    checkStatus("midreset", 0);
    sendWord(8'h96, 1'b1);
    drain();
    checkStatus("post reset", 0);

    // Random traffic, occasional framing errors.
    feCount = 0; expFe = 0;
    for (int i = 0; i < 8; i++)
      sendWord(8'($urandom_range(0, 255)), $urandom_range(0, 4) != 0);
    drain();
    checkStatus("random", 0);
    check("random frame_err", feCount, expFe);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
